// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared defaults and PC action encoding for the fetch PC generator
package pc_gen_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int ILEN_BYTES = 4;
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_NEXT,
    ACT_JUMP,
    ACT_RET,
    ACT_TRAP,
    ACT_FAULT
  } pc_act_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; top points at the newest entry, full pushes overwrite the oldest
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   top;
  logic [CW-1:0]   count;
  assign top_data = mem[top];
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  always_ff @(posedge i_clk) begin
    if (push) mem[top + 1'b1] <= push_data;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      top   <= '0;
      count <= '0;
    end else if (push) begin
      top   <= top + 1'b1;
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      top   <= top - 1'b1;
      count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with trap/stall/ret/jump/next priority, misaligned-target
// rejection and a return-address stack resolving ret targets
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_nextPC_DV,
  input  logic            i_jump_DV,
  input  logic [XLEN-1:0] i_jump_address,
  input  logic            i_call_DV,
  input  logic            i_ret_DV,
  input  logic            i_trap_DV,
  input  logic [XLEN-1:0] i_trap_vector,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_PC_plus4,
  output logic            o_misaligned,
  output logic [XLEN-1:0] o_bad_addr,
  output logic            o_ras_empty,
  output logic            o_ras_full
);
  pc_act_e         act;
  logic            jump_mis, push, pop;
  logic [XLEN-1:0] pc_d, ras_top;
  assign o_PC_plus4 = o_PC + XLEN'(ILEN_BYTES);
  assign jump_mis   = |i_jump_address[1:0];
  // An empty-stack ret degrades to a plain jump, sharing the alignment rule
  always_comb begin
    act  = i_trap_DV ? ACT_TRAP :
           i_stall ? ACT_HOLD :
           (i_ret_DV && !o_ras_empty) ? ACT_RET :
           (i_ret_DV || i_jump_DV) ? (jump_mis ? ACT_FAULT : ACT_JUMP) :
           i_nextPC_DV ? ACT_NEXT : ACT_HOLD;
    push = act == ACT_JUMP && i_call_DV && !i_ret_DV;
    pop  = act == ACT_RET;
    pc_d = act == ACT_TRAP ? (i_trap_vector & ~XLEN'(3)) :
           act == ACT_RET ? ras_top :
           act == ACT_JUMP ? i_jump_address :
           act == ACT_NEXT ? o_PC_plus4 : o_PC;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_PC         <= RESET_VECTOR;
      o_misaligned <= 1'b0;
      o_bad_addr   <= '0;
    end else begin
      o_PC         <= pc_d;
      o_misaligned <= act == ACT_FAULT;
      if (act == ACT_FAULT) o_bad_addr <= i_jump_address;
    end
  end
  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (o_PC_plus4),
    .top_data  (ras_top),
    .empty     (o_ras_empty),
    .full      (o_ras_full)
  );
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter for the RISC-V CPU core; drives the fetch address every cycle.
- Adds to the basic increment/jump PC: reset vector, stall, trap redirect, misaligned-target detection, and a small return-address stack (RAS) that resolves `ret` targets at the PC.
- Sits between the control unit, which asserts the redirect strobes, and instruction memory, which consumes o_PC.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- RAS_DEPTH, 4, return-address stack entries; power of two, minimum 2.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_stall  input  1  hold the PC; blocks every update except trap.
- i_nextPC_DV  input  1  advance PC by 4.
- i_jump_DV  input  1  load i_jump_address.
- i_jump_address  input  XLEN  jump/branch target.
- i_call_DV  input  1  qualifies a jump as a call: push PC+4 onto the RAS.
- i_ret_DV  input  1  return: pop the RAS and load the popped value.
- i_trap_DV  input  1  trap redirect.
- i_trap_vector  input  XLEN  trap handler address.
- o_PC  output  XLEN  current PC.
- o_PC_plus4  output  XLEN  o_PC + 4, combinational.
- o_misaligned  output  1  one-cycle pulse: rejected target.
- o_bad_addr  output  XLEN  rejected target; valid while o_misaligned is high.
- o_ras_empty  output  1  RAS holds no entries.
- o_ras_full  output  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset, sampled on a rising edge with i_rst_n=0:
  - o_PC=RESET_VECTOR.
  - RAS count=0 and top pointer=0; o_ras_empty=1, o_ras_full=0.
  - o_misaligned=0, o_bad_addr=0.
  - Reset overrides every other input, including mid-stall and mid-trap.
- Update priority per cycle: trap > stall(hold) > ret > jump > next > hold. Exactly one action is taken per cycle.
- Trap: o_PC <= {i_trap_vector[XLEN-1:2],2'b00}. Trap ignores i_stall, never faults, and leaves the RAS untouched.
- Stall (no trap): o_PC holds and the RAS holds. o_misaligned is 0 during a stall.
- Jump: the new o_PC appears one cycle after the strobe.
  - If i_jump_address[1:0]!=0: o_PC holds, o_misaligned=1 and o_bad_addr=i_jump_address for the next cycle, RAS unchanged (the call push is suppressed).
  - Otherwise: o_PC <= i_jump_address.
- Call: i_call_DV is meaningful only together with a taken, aligned jump. It pushes o_PC+4 (the pre-jump value) at the same edge as the jump. i_call_DV without i_jump_DV is ignored.
- Ret: o_PC <= the top entry, and the entry is popped.
  - If the RAS is empty: fall back to i_jump_address with the jump alignment rule; count stays 0.
  - Popped entries are always aligned, so no check is applied to them.
- Next: o_PC <= o_PC+4, modulo 2^XLEN. 32'hFFFF_FFFC wraps to 0 with no flag.
- RAS is a circular buffer with a top pointer and a count.
  - Push: top <= top+1 (mod RAS_DEPTH); write the entry; count saturates at RAS_DEPTH.
  - Push when full: overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop: read entry[top]; top <= top-1; count-1.
  - Simultaneous call and ret cannot occur, because ret outranks jump; the ret wins and no push happens.
- o_misaligned is a single-cycle pulse. It is re-asserted on each new faulting jump, including back-to-back faults.
- No output is combinationally dependent on the strobes; o_PC_plus4 depends only on o_PC.

Decomposition:
- Shared core package holds:
  - XLEN default and RESET_VECTOR default.
  - ILEN_BYTES=4.
  - A PC action encoding enum: ACT_HOLD, ACT_NEXT, ACT_JUMP, ACT_RET, ACT_TRAP, ACT_FAULT.
- One sub-module, pc_ras: parametrised circular stack with push/pop/count/full/empty. pc_gen holds the priority decode and the PC register.

Test Plan:
- Reset then 3 cycles of i_nextPC_DV, RESET_VECTOR=0x100 -> o_PC sequence 0x100, 0x104, 0x108, 0x10C; o_PC_plus4=0x110.
- Jump to 0x2002 from PC=0x40 -> o_PC stays 0x40; o_misaligned=1 for exactly one cycle; o_bad_addr=0x2002.
- Call to 0x800 at PC=0x10, call to 0x900 at 0x800, ret, ret -> o_PC sequence 0x800, 0x900, 0x804, 0x14; o_ras_empty=1 at the end.
- RAS_DEPTH=4: five calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400, then five rets with i_jump_address=0xAAA0 -> returns 0x404, 0x304, 0x204, 0x104, then the empty fallback 0xAAA0; o_ras_full=1 after the 4th call.
- i_stall=1 with i_jump_DV and i_trap_DV (vector 0x1C3) asserted in the same cycle -> o_PC=0x1C0 next cycle; with trap deasserted and stall held, o_PC holds 0x1C0.
- PC=0xFFFF_FFFC + next -> o_PC=0x0. Assert i_rst_n=0 during a stalled cycle after two calls -> o_PC=RESET_VECTOR and o_ras_empty=1.
